// File: rtl/ld_mem_port.sv
// rtl/ld_mem_port.sv - load-unit memory port: credit-limited reads, latency pipe, skid FIFO
//
// Purpose: accepts load requests, issues reads to a fixed-latency memory and
// returns the words, tagged with their mode bits, as tokens in request order
// through a small FIFO. The credit rule reserves a FIFO slot for every read
// in flight, so a word that comes back always has a free slot.
//
// Ports:
//   clock, reset       - clock; synchronous active-high reset
//   i_req/i_mode/i_addr - load request (mode bit0 = attribute, bit1 = last word)
//   o_stall            - request not accepted this cycle
//   o_mem_re/o_mem_addr/i_mem_rdata - memory read port (RD_LATENCY cycles)
//   o_v/o_a/o_r/o_d    - token at the FIFO head
//   i_n                - downstream nack; the head token is kept
//   o_busy             - reads in flight or FIFO not empty
//   o_end              - one-cycle pulse after a token with r=1 is consumed
module ld_mem_port #(
  parameter int WIDTH_ADDR = 8,
  parameter int WIDTH_DATA = 32,
  parameter int RD_LATENCY = 2,
  parameter int DEPTH_SKID = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH_ADDR-1:0] i_addr,
  output logic                  o_stall,
  output logic                  o_mem_re,
  output logic [WIDTH_ADDR-1:0] o_mem_addr,
  input  logic [WIDTH_DATA-1:0] i_mem_rdata,
  output logic                  o_v,
  output logic                  o_a,
  output logic                  o_r,
  output logic [WIDTH_DATA-1:0] o_d,
  input  logic                  i_n,
  output logic                  o_busy,
  output logic                  o_end
);

  localparam int PW = $clog2(DEPTH_SKID);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_SKID);

  logic [CW-1:0]         inflight;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_use;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [WIDTH_DATA-1:0] fifo_data [DEPTH_SKID];
  logic [1:0]            fifo_mode [DEPTH_SKID];
  logic [RD_LATENCY-1:0] sr_v;
  logic [1:0]            sr_mode [RD_LATENCY];
  logic                  accept;
  logic                  capture;
  logic                  pop;
  logic                  empty;

  // Credit covers both reads in flight and words already queued.
  assign credit_use = {1'b0, inflight} + {1'b0, count};
  assign o_stall    = credit_use >= {1'b0, DEPTH_C};

  // No read may leave while reset is held, even if the state looks idle.
  assign accept     = i_req & ~o_stall & ~reset;
  assign o_mem_re   = accept;
  assign o_mem_addr = i_addr;

  // The last shift stage lines up with the cycle the memory presents data.
  assign capture = sr_v[RD_LATENCY-1];

  assign empty  = (count == '0);
  assign o_v    = ~empty;
  assign o_d    = fifo_data[rd_ptr];
  assign o_a    = fifo_mode[rd_ptr][0];
  assign o_r    = fifo_mode[rd_ptr][1];
  assign pop    = o_v & ~i_n;
  assign o_busy = (inflight != '0) | ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_v     <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_end    <= 1'b0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        sr_v[i] <= sr_v[i-1];
      end
      sr_v[0] <= accept;

      case ({accept, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case ({capture, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      o_end <= pop & o_r;
    end
  end

  // Mode bits ride along with the valid bits; they are only looked at when
  // the matching valid bit is set, so they need no reset.
  always_ff @(posedge clock) begin
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      sr_mode[i] <= sr_mode[i-1];
    end
    sr_mode[0] <= i_mode;
  end

  always_ff @(posedge clock) begin
    if (capture & ~reset) begin
      fifo_data[wr_ptr] <= i_mem_rdata;
      fifo_mode[wr_ptr] <= sr_mode[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_ld_mem_port.sv
// tb/tb_ld_mem_port.sv - randomized scoreboard bench for ld_mem_port
module tb_ld_mem_port;

  localparam int WA    = 8;
  localparam int WD    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [1:0]    i_mode = 2'b00;
  logic [WA-1:0] i_addr = '0;
  logic          i_n = 1'b0;
  logic [WD-1:0] i_mem_rdata;
  logic          o_stall, o_mem_re, o_v, o_a, o_r, o_busy, o_end;
  logic [WA-1:0] o_mem_addr;
  logic [WD-1:0] o_d;

  always #5 clock = ~clock;

  ld_mem_port #(
    .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .RD_LATENCY(LAT), .DEPTH_SKID(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .i_req(i_req), .i_mode(i_mode), .i_addr(i_addr),
    .o_stall(o_stall), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .o_v(o_v), .o_a(o_a), .o_r(o_r), .o_d(o_d),
    .i_n(i_n), .o_busy(o_busy), .o_end(o_end)
  );

  // Memory with LAT cycles of read latency; cycles without a read return noise.
  logic [WD-1:0] mem [256];
  logic [WD-1:0] rd_pipe [LAT];

  always @(posedge clock) begin
    rd_pipe[0] <= o_mem_re ? mem[o_mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    int          ready;
    logic [WD-1:0] data;
    logic        a;
    logic        r;
  } tok_t;

  typedef struct {
    logic [1:0]    mode;
    logic [WA-1:0] addr;
  } rq_t;

  tok_t exp_q[$];
  rq_t  req_q[$];

  // outstanding = tokens accepted but not yet consumed, i.e. credit in use
  int            outstanding = 0;
  int            cur_cyc = 0;
  logic          exp_stall = 1'b0;
  logic          exp_re = 1'b0;
  logic          exp_busy = 1'b0;
  logic          in_reset = 1'b1;
  logic [WA-1:0] exp_addr = '0;
  logic          end_exp = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_cyc);
    end
  endtask

  task automatic add_req(input logic [1:0] mode, input logic [WA-1:0] addr);
    rq_t r;
    r.mode = mode;
    r.addr = addr;
    req_q.push_back(r);
  endtask

  // One clock cycle of stimulus. nmode: 0 = ack, 1 = nack, 2 = random.
  // gate=1 lets the requester randomly leave a cycle idle.
  task automatic step(input int nmode, input bit rst, input bit gate);
    tok_t t;
    @(posedge clock);
    #1;
    cur_cyc++;
    reset = rst;
    i_n = (nmode == 2) ? 1'($urandom_range(0, 1)) : (nmode == 1);
    if (req_q.size() > 0 && (!gate || $urandom_range(0, 3) != 0)) begin
      i_req  = 1'b1;
      i_mode = req_q[0].mode;
      i_addr = req_q[0].addr;
    end else begin
      i_req  = 1'b0;
      i_mode = 2'($urandom);
      i_addr = WA'($urandom);
    end
    in_reset  = rst;
    exp_busy  = (outstanding != 0);
    exp_stall = (outstanding >= DEPTH);
    exp_re    = i_req && !exp_stall && !rst;
    exp_addr  = i_addr;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else if (exp_re) begin
      t.ready = cur_cyc + LAT + 1;
      t.data  = mem[i_addr];
      t.a     = i_mode[0];
      t.r     = i_mode[1];
      exp_q.push_back(t);
      outstanding++;
      void'(req_q.pop_front());
    end
  endtask

  // Monitor: compares every visible output against the model once per cycle.
  initial begin
    logic v;
    forever begin
      @(negedge clock);
      if (cur_cyc > 0) begin
        chk("mem_re", o_mem_re, exp_re);
        if (in_reset) begin
          end_exp = 1'b0;
        end else begin
          chk("stall", o_stall, exp_stall);
          chk("busy", o_busy, exp_busy);
          chk("end", o_end, end_exp);
          if (exp_re) chk("mem_addr", o_mem_addr, exp_addr);
          v = (exp_q.size() > 0) && (exp_q[0].ready <= cur_cyc);
          chk("o_v", o_v, v);
          end_exp = 1'b0;
          if (v) begin
            if (o_v) begin
              chk("o_d", o_d, exp_q[0].data);
              chk("o_a", o_a, exp_q[0].a);
              chk("o_r", o_r, exp_q[0].r);
            end
            if (!i_n) begin
              end_exp = exp_q[0].r;
              void'(exp_q.pop_front());
              outstanding--;
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5] = 32'hA5A5A5A5;

    repeat (3) step(0, 1, 0);

    // single read of the last word
    add_req(2'b10, 8'h05);
    repeat (8) step(0, 0, 0);

    // back-to-back burst with no backpressure
    for (int i = 0; i < 6; i++) add_req((i == 5) ? 2'b10 : 2'b00, WA'($urandom));
    repeat (12) step(0, 0, 0);

    // nack held: credit fills, then drains one token per cycle
    for (int i = 0; i < 6; i++) add_req(2'($urandom), WA'($urandom));
    repeat (8) step(1, 0, 0);
    repeat (14) step(0, 0, 0);

    // attribute word
    add_req(2'b01, WA'($urandom));
    repeat (6) step(0, 0, 0);

    // reset with reads in flight and tokens queued
    for (int i = 0; i < 6; i++) add_req(2'($urandom), WA'($urandom));
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    repeat (14) step(0, 0, 0);

    // random traffic, random nack, occasional reset
    for (int c = 0; c < 800; c++) begin
      if (req_q.size() < 3) add_req(2'($urandom), WA'($urandom));
      step(2, ($urandom_range(0, 149) == 0), 1);
    end

    // drain with a bounded budget
    for (int c = 0; c < 200 && (exp_q.size() > 0 || req_q.size() > 0); c++) step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clock);
    #1;
    chk("drain_tokens", exp_q.size(), 0);
    chk("drain_reqs", req_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
